// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register-bank write port among NUM_REQ producers,
// with a one-register-per-cycle clear sweep.
module reg_write_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      clear_start,
    output logic [NUM_REGS-1:0]       wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic [2:0]                grant_id,
    output logic                      busy,
    output logic                      clear_done,
    output logic                      addr_err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(NUM_REGS + 1);
    localparam logic [PTR_W:0]   NUM_REQ_L  = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_REQ   = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] NUM_REGS_L = CNT_W'(NUM_REGS);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    clr_cnt_q, clr_cnt_d;
    logic [NUM_REGS-1:0] wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [2:0]          grant_id_q, grant_id_d;
    logic                busy_q, busy_d;
    logic                clear_done_q, clear_done_d;
    logic                addr_err_q, addr_err_d;

    logic                arb_en;
    logic                grant_vld;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W:0]      cand;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

    // Rotating priority search starting at rr_ptr; a pending clear blocks all grants.
    always_comb begin
        arb_en    = !reset && (state_q == IDLE) && !clear_start;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        req_ready = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(off);
            if (cand >= NUM_REQ_L) begin
                cand = cand - NUM_REQ_L;
            end
            if (arb_en && !grant_vld && req_valid[cand[PTR_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[PTR_W-1:0];
            end
        end
        if (grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign sel_addr = req_addr[32'(grant_idx)*ADDR_W +: ADDR_W];
    assign sel_data = req_data[32'(grant_idx)*DATA_W +: DATA_W];

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        clr_cnt_d    = clr_cnt_q;
        wr_en_d      = '0;
        wr_addr_d    = '0;
        wr_data_d    = '0;
        grant_id_d   = '0;
        busy_d       = 1'b0;
        clear_done_d = 1'b0;
        addr_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d    = CLEAR;
                    busy_d     = 1'b1;
                    wr_en_d[0] = 1'b1;
                    clr_cnt_d  = CNT_W'(1);
                end else if (grant_vld) begin
                    rr_ptr_d   = (grant_idx == LAST_REQ) ? '0 : grant_idx + 1'b1;
                    wr_addr_d  = sel_addr;
                    grant_id_d = 3'(grant_idx);
                    if (32'(sel_addr) < NUM_REGS) begin
                        wr_data_d = sel_data;
                        for (int unsigned r = 0; r < NUM_REGS; r++) begin
                            wr_en_d[r] = (32'(sel_addr) == r);
                        end
                    end else begin
                        addr_err_d = 1'b1;
                    end
                end
            end
            CLEAR: begin
                // Counter holds the index of the write being launched; NUM_REGS marks the done cycle.
                if (clr_cnt_q == NUM_REGS_L) begin
                    state_d      = IDLE;
                    clear_done_d = 1'b1;
                    clr_cnt_d    = '0;
                end else begin
                    busy_d    = 1'b1;
                    clr_cnt_d = clr_cnt_q + 1'b1;
                    wr_addr_d = ADDR_W'(clr_cnt_q);
                    for (int unsigned r = 0; r < NUM_REGS; r++) begin
                        wr_en_d[r] = (32'(clr_cnt_q) == r);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            clr_cnt_q    <= '0;
            wr_en_q      <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            grant_id_q   <= '0;
            busy_q       <= 1'b0;
            clear_done_q <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            clr_cnt_q    <= clr_cnt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            grant_id_q   <= grant_id_d;
            busy_q       <= busy_d;
            clear_done_q <= clear_done_d;
            addr_err_q   <= addr_err_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign grant_id   = grant_id_q;
    assign busy       = busy_q;
    assign clear_done = clear_done_q;
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: vector table plus clear/reset sequences,
// expected outputs queued per driven cycle and compared after the following edge.
module tb_reg_write_arbiter;

    typedef struct packed {
        logic [7:0]  en;
        logic [3:0]  addr;
        logic [15:0] data;
        logic [2:0]  gid;
        logic        busy;
        logic        done;
        logic        err;
    } out_t;

    typedef struct packed {
        logic        rst;
        logic        clr;
        logic [3:0]  valid;
        logic [15:0] addr;
        logic [63:0] data;
        logic [3:0]  rdy;
        out_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [15:0] req_addr = '0;
    logic [63:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        clear_start = 1'b0;
    logic [7:0]  wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [2:0]  grant_id;
    logic        busy;
    logic        clear_done;
    logic        addr_err;

    int unsigned checks = 0;
    int unsigned errors = 0;
    out_t        sb[$];
    vec_t        tbl[$];

    reg_write_arbiter #(.NUM_REQ(4), .NUM_REGS(8), .ADDR_W(4), .DATA_W(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .clear_start(clear_start),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .grant_id(grant_id),
        .busy(busy), .clear_done(clear_done), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    function automatic out_t zo();
        return '0;
    endfunction

    function automatic out_t wo(logic [7:0] en, logic [3:0] a, logic [15:0] d, logic [2:0] g);
        out_t o = '0;
        o.en = en; o.addr = a; o.data = d; o.gid = g;
        return o;
    endfunction

    function automatic out_t eo(logic [2:0] g);
        out_t o = '0;
        o.gid = g; o.err = 1'b1;
        return o;
    endfunction

    function automatic out_t co(int unsigned k);
        out_t o = '0;
        o.en = 8'(1) << k; o.addr = 4'(k); o.busy = 1'b1;
        return o;
    endfunction

    function automatic out_t dn();
        out_t o = '0;
        o.done = 1'b1;
        return o;
    endfunction

    function automatic vec_t mv(logic rst, logic clr, logic [3:0] v, logic [15:0] a,
                                logic [63:0] d, logic [3:0] rdy, out_t e);
        vec_t x;
        x.rst = rst; x.clr = clr; x.valid = v; x.addr = a; x.data = d; x.rdy = rdy; x.exp = e;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, check the combinational grant, then check registered outputs.
    task automatic step(input vec_t v);
        out_t e;
        reset = v.rst; clear_start = v.clr;
        req_valid = v.valid; req_addr = v.addr; req_data = v.data;
        sb.push_back(v.exp);
        #3;
        chk("req_ready", 32'(req_ready), 32'(v.rdy));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("wr_en", 32'(wr_en), 32'(e.en));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("clear_done", 32'(clear_done), 32'(e.done));
        chk("addr_err", 32'(addr_err), 32'(e.err));
        if (e.en != 0) begin
            chk("wr_addr", 32'(wr_addr), 32'(e.addr));
            chk("wr_data", 32'(wr_data), 32'(e.data));
        end
        if (e.en != 0 || e.err) chk("grant_id", 32'(grant_id), 32'(e.gid));
    endtask

    initial begin
        // Reset, single request, fairness, out-of-range address
        tbl.push_back(mv(1, 0, 4'b0000, 16'h0000, 64'h0, 4'b0000, zo()));
        tbl.push_back(mv(1, 0, 4'b0001, 16'h0003, 64'hBEEF, 4'b0000, zo()));
        tbl.push_back(mv(0, 0, 4'b0001, 16'h0003, 64'hBEEF, 4'b0001, wo(8'h08, 3, 16'hBEEF, 0)));
        tbl.push_back(mv(0, 0, 4'b0000, 16'h0000, 64'h0, 4'b0000, zo()));
        tbl.push_back(mv(0, 0, 4'b1000, 16'h5000, 64'h3333_0000_0000_0000, 4'b1000,
                         wo(8'h20, 5, 16'h3333, 3)));
        for (int r = 0; r < 2; r++) begin
            tbl.push_back(mv(0, 0, 4'b1111, 16'h7621, 64'h8888_4444_2222_1111, 4'b0001,
                             wo(8'h02, 1, 16'h1111, 0)));
            tbl.push_back(mv(0, 0, 4'b1111, 16'h7621, 64'h8888_4444_2222_1111, 4'b0010,
                             wo(8'h04, 2, 16'h2222, 1)));
            tbl.push_back(mv(0, 0, 4'b1111, 16'h7621, 64'h8888_4444_2222_1111, 4'b0100,
                             wo(8'h40, 6, 16'h4444, 2)));
            tbl.push_back(mv(0, 0, 4'b1111, 16'h7621, 64'h8888_4444_2222_1111, 4'b1000,
                             wo(8'h80, 7, 16'h8888, 3)));
        end
        tbl.push_back(mv(0, 0, 4'b0100, 16'h0C00, 64'h0000_5555_0000_0000, 4'b0100, eo(2)));
        tbl.push_back(mv(0, 0, 4'b1001, 16'h7001, 64'h8888_0000_0000_1111, 4'b1000,
                         wo(8'h80, 7, 16'h8888, 3)));
        tbl.push_back(mv(0, 0, 4'b0001, 16'h7001, 64'h8888_0000_0000_1111, 4'b0001,
                         wo(8'h02, 1, 16'h1111, 0)));

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Idle stability, then pointer still at 1: requester 2 wins over 0 and 3
        for (int i = 0; i < 20; i++) step(mv(0, 0, 4'b0000, 16'h0, 64'h0, 4'b0000, zo()));
        step(mv(0, 0, 4'b1101, 16'h7601, 64'h8888_4444_0000_1111, 4'b0100, wo(8'h40, 6, 16'h4444, 2)));
        step(mv(0, 0, 4'b1001, 16'h7601, 64'h8888_4444_0000_1111, 4'b1000, wo(8'h80, 7, 16'h8888, 3)));
        step(mv(0, 0, 4'b0001, 16'h7601, 64'h8888_4444_0000_1111, 4'b0001, wo(8'h02, 1, 16'h1111, 0)));

        // Clear colliding with a request from requester 1; extra clear_start pulses are ignored
        step(mv(0, 1, 4'b0010, 16'h0040, 64'h0000_0000_ABCD_0000, 4'b0000, co(0)));
        for (int unsigned k = 1; k < 8; k++)
            step(mv(0, (k == 3), 4'b0010, 16'h0040, 64'h0000_0000_ABCD_0000, 4'b0000, co(k)));
        step(mv(0, 1, 4'b0010, 16'h0040, 64'h0000_0000_ABCD_0000, 4'b0000, dn()));
        step(mv(0, 0, 4'b0010, 16'h0040, 64'h0000_0000_ABCD_0000, 4'b0010, wo(8'h10, 4, 16'hABCD, 1)));
        step(mv(0, 0, 4'b0000, 16'h0, 64'h0, 4'b0000, zo()));

        // Reset while the sweep shows k=4: no done pulse, pointer back to 0
        step(mv(0, 1, 4'b0000, 16'h0, 64'h0, 4'b0000, co(0)));
        for (int unsigned k = 1; k < 5; k++) step(mv(0, 0, 4'b0000, 16'h0, 64'h0, 4'b0000, co(k)));
        step(mv(1, 0, 4'b0000, 16'h0, 64'h0, 4'b0000, zo()));
        for (int i = 0; i < 10; i++) step(mv(0, 0, 4'b0000, 16'h0, 64'h0, 4'b0000, zo()));
        step(mv(0, 0, 4'b1010, 16'h3000, 64'h9999_0000_1234_0000, 4'b0010, wo(8'h01, 0, 16'h1234, 1)));
        step(mv(0, 0, 4'b1000, 16'h3000, 64'h9999_0000_1234_0000, 4'b1000, wo(8'h08, 3, 16'h9999, 3)));
        step(mv(0, 0, 4'b0000, 16'h0, 64'h0, 4'b0000, zo()));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares the single write port of the processor's register bank among NUM_REQ producers, for example ALU, load unit, move/immediate path and debug.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Decodes the granted address into the per-register one-hot enable vector that drives the 16-bit registers.
- Provides a sequenced clear operation that zeroes every register, one per cycle.

Parameters:
- NUM_REQ, 4, number of write requesters (2..8).
- NUM_REGS, 8, number of registers in the bank (2..16).
- ADDR_W, 4, register address width; must satisfy 2^ADDR_W >= NUM_REGS.
- DATA_W, 16, register data width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester write request.
- req_addr  input  NUM_REQ*ADDR_W  packed target addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*DATA_W  packed write data; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot grant; a handshake completes when valid & ready.
- clear_start  input  1  single-cycle pulse that starts the clear sequence.
- wr_en  output  NUM_REGS  one-hot register enable, registered.
- wr_addr  output  ADDR_W  address of the current write, registered.
- wr_data  output  DATA_W  data for the current write, registered.
- grant_id  output  3  index of the requester whose write is on wr_*; valid while |wr_en.
- busy  output  1  high while the clear sequence runs.
- clear_done  output  1  one-cycle pulse after the last clear write.
- addr_err  output  1  one-cycle pulse when an accepted request targets an address >= NUM_REGS.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, clear counter=0; wr_en, wr_addr, wr_data, grant_id, busy, clear_done and addr_err are all 0. req_ready is 0 during the reset cycle.
- States:
  - IDLE: arbitrate requests.
  - CLEAR: sweep all registers with zero data.
- IDLE arbitration:
  - req_ready is combinational from req_valid and rr_ptr.
  - Search order is rr_ptr, rr_ptr+1, … mod NUM_REQ; the first valid requester gets ready=1 and all others get 0.
  - At most one handshake per cycle.
  - If no request is valid, req_ready=0 and rr_ptr is unchanged.
- On a handshake by requester i:
  - rr_ptr <= (i+1) mod NUM_REQ.
  - Next cycle: wr_en = one-hot(addr), wr_addr = addr, wr_data = data, grant_id = i, all for exactly one cycle.
  - Handshake-to-write latency is 1 cycle.
  - Sustained throughput is 1 write per cycle.
- Requester rules: req_valid, req_addr and req_data stay stable until the handshake. A requester may drop valid only after its handshake.
- Out-of-range address (addr >= NUM_REGS):
  - The handshake is still accepted and rr_ptr still advances.
  - Next cycle: wr_en=0, addr_err=1, grant_id=i.
- clear_start in IDLE:
  - Goes to CLEAR on the next edge.
  - Has priority over requests in the same cycle: req_ready=0 that cycle, no grant, rr_ptr unchanged.
- CLEAR sequence:
  - busy=1 and req_ready=0 for all requesters.
  - Counter k runs 0..NUM_REGS-1, one per cycle; the write on the cycle for k is wr_en=one-hot(k), wr_addr=k, wr_data=0, grant_id=0.
  - After the k=NUM_REGS-1 write, the next cycle has clear_done=1, busy=0, wr_en=0, and the state returns to IDLE.
  - Arbitration resumes in that same cycle, with writes appearing 1 cycle later.
  - clear_start is ignored while busy=1.
- Sequence timing: busy rises the cycle after clear_start, together with the k=0 write. The sequence is NUM_REGS write cycles plus one done cycle.
- Reset mid-sequence (any state): the sequence is abandoned with no clear_done and no partial write on the cycle after reset. Outputs return to reset values on the next edge.
- wr_en is never multi-hot. wr_en is 0 on every cycle without a valid write.

Test Plan:
- Reset, then single request: req_valid=0001, addr=3, data=16'hBEEF → req_ready=0001 same cycle; next cycle wr_en=8'b0000_1000, wr_data=BEEF, grant_id=0; rr_ptr becomes 1.
- Round-robin fairness: all four requesters hold valid continuously for 8 cycles → grants in order 0,1,2,3,0,1,2,3; one wr_en pulse per cycle; each requester granted exactly twice.
- Clear vs request collision: clear_start=1 with req_valid=0010 on the same cycle → no ready that cycle; wr_en walks 01,02,04,…,80 over 8 cycles with wr_data=0; clear_done pulses on cycle 9; requester 1 is granted on cycle 9 and its write appears on cycle 10.
- Out-of-range address: NUM_REGS=8, requester 2 writes addr=12 → handshake accepted; next cycle wr_en=0, addr_err=1, grant_id=2; a following request from requester 3 is granted first.
- Reset mid-clear: reset asserted at k=4 → the next cycle has busy=0, wr_en=0, and clear_done is never pulsed; a new request after reset is granted with rr_ptr=0 priority.
- Idle stability: no valid and no clear for 20 cycles → req_ready=0, wr_en=0, addr_err=0 and clear_done=0 throughout; rr_ptr unchanged, so the next grant goes to the lowest index at or after the old pointer.
